// File: rtl/operand_issue_if.sv
// Handshake and bus bundle for the operand_issue stage: upstream instruction
// channel, writeback port, and the single-slot output toward the ALU.
interface operand_issue_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_N  = 8
);
    localparam int unsigned AW = $clog2(REG_N);

    // Upstream instruction channel
    logic              in_valid_i;
    logic              in_ready_o;
    logic [2:0]        in_opcode_i;
    logic [AW-1:0]     in_rs_addr_i;
    logic [AW-1:0]     in_rt_addr_i;
    logic [AW-1:0]     in_rd_addr_i;

    // Writeback port into the register file
    logic              wb_en_i;
    logic [AW-1:0]     wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;

    // Output slot toward the ALU
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] rs_o;
    logic [DATA_W-1:0] rt_o;
    logic [2:0]        opcode_o;
    logic [AW-1:0]     rd_addr_o;

    // Performance counter
    logic [7:0]        issue_count_o;

    // Environment side: drives instructions, writebacks and downstream ready
    modport master (
        output in_valid_i, in_opcode_i, in_rs_addr_i, in_rt_addr_i, in_rd_addr_i,
        output wb_en_i, wb_addr_i, wb_data_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, rs_o, rt_o, opcode_o, rd_addr_o, issue_count_o
    );

    // Stage side
    modport slave (
        input  in_valid_i, in_opcode_i, in_rs_addr_i, in_rt_addr_i, in_rd_addr_i,
        input  wb_en_i, wb_addr_i, wb_data_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, rs_o, rt_o, opcode_o, rd_addr_o, issue_count_o
    );
endinterface

// File: rtl/operand_issue.sv
// Operand-fetch / issue stage ahead of the 8-bit ALU. Holds the register
// file, reads two sources with same-cycle writeback bypass, and registers the
// issued instruction into a single output slot. Counts accepted instructions.
module operand_issue #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_N  = 8
) (
    input logic             clk_i,
    input logic             rst_n_i,
    operand_issue_if.slave  bus
);
    localparam int unsigned AW = $clog2(REG_N);

    logic [DATA_W-1:0] regs [REG_N];

    logic              slot_valid;
    logic [DATA_W-1:0] slot_rs;
    logic [DATA_W-1:0] slot_rt;
    logic [2:0]        slot_opcode;
    logic [AW-1:0]     slot_rd;
    logic [7:0]        issue_count;

    logic              ready;
    logic              acc;
    logic              wb_write;
    logic [DATA_W-1:0] rs_operand;
    logic [DATA_W-1:0] rt_operand;

    // Handshake: a full slot can still accept when it drains this cycle
    always_comb begin
        ready    = ~slot_valid | bus.out_ready_i;
        acc      = bus.in_valid_i & ready;
        wb_write = bus.wb_en_i & (bus.wb_addr_i != '0);
    end

    // Source operand selection: r0 reads zero, otherwise bypass a matching writeback
    always_comb begin
        rs_operand = '0;
        rt_operand = '0;
        if (bus.in_rs_addr_i != '0) begin
            if (wb_write && bus.wb_addr_i == bus.in_rs_addr_i)
                rs_operand = bus.wb_data_i;
            else
                rs_operand = regs[bus.in_rs_addr_i];
        end
        if (bus.in_rt_addr_i != '0) begin
            if (wb_write && bus.wb_addr_i == bus.in_rt_addr_i)
                rt_operand = bus.wb_data_i;
            else
                rt_operand = regs[bus.in_rt_addr_i];
        end
    end

    // Register file write port; r0 is never written so it stays zero
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs <= '{default: '0};
        end else if (wb_write) begin
            regs[bus.wb_addr_i] <= bus.wb_data_i;
        end
    end

    // Output slot: capture on accept, empty on drain without a replacement
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_valid  <= 1'b0;
            slot_rs     <= '0;
            slot_rt     <= '0;
            slot_opcode <= '0;
            slot_rd     <= '0;
        end else if (acc) begin
            slot_valid  <= 1'b1;
            slot_rs     <= rs_operand;
            slot_rt     <= rt_operand;
            slot_opcode <= bus.in_opcode_i;
            slot_rd     <= bus.in_rd_addr_i;
        end else if (bus.out_ready_i && slot_valid) begin
            slot_valid  <= 1'b0;
        end
    end

    // Issue counter, wraps modulo 256
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            issue_count <= '0;
        end else if (acc) begin
            issue_count <= issue_count + 8'd1;
        end
    end

    assign bus.in_ready_o    = ready;
    assign bus.out_valid_o   = slot_valid;
    assign bus.rs_o          = slot_rs;
    assign bus.rt_o          = slot_rt;
    assign bus.opcode_o      = slot_opcode;
    assign bus.rd_addr_o     = slot_rd;
    assign bus.issue_count_o = issue_count;
endmodule

// File: tb/tb_operand_issue.sv
// Scoreboard bench for operand_issue: stimulus pushes hand-computed expected
// slot contents; a monitor pops and compares whenever the slot is consumed.
module tb_operand_issue;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_N  = 8;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] rs;
        logic [7:0] rt;
        logic [2:0] rd;
    } exp_t;

    logic clk_i;
    logic rst_n_i;

    operand_issue_if #(.DATA_W(DATA_W), .REG_N(REG_N)) bus ();

    operand_issue #(.DATA_W(DATA_W), .REG_N(REG_N)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    exp_t sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Register contents after the write phase, hand-derived: r1=55 r2=33 r4=0F
    logic [7:0] reg_img [8] = '{8'h00, 8'h55, 8'h33, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: a consumed slot must match the oldest expected entry
    always @(negedge clk_i) begin
        if (rst_n_i && bus.out_valid_o === 1'b1 && bus.out_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {31'd0, bus.out_valid_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("opcode", {29'd0, bus.opcode_o}, {29'd0, e.op});
                check("rs",     {24'd0, bus.rs_o},     {24'd0, e.rs});
                check("rt",     {24'd0, bus.rt_o},     {24'd0, e.rt});
                check("rd",     {29'd0, bus.rd_addr_o},{29'd0, e.rd});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.in_valid_i = 1'b0;
        bus.wb_en_i    = 1'b0;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [2:0] rs,
                             input logic [2:0] rt, input logic [2:0] rd);
        bus.in_valid_i   = 1'b1;
        bus.in_opcode_i  = op;
        bus.in_rs_addr_i = rs;
        bus.in_rt_addr_i = rt;
        bus.in_rd_addr_i = rd;
    endtask

    task automatic set_wb(input logic [2:0] a, input logic [7:0] d);
        bus.wb_en_i   = 1'b1;
        bus.wb_addr_i = a;
        bus.wb_data_i = d;
    endtask

    initial begin
        logic [2:0] a;
        logic [2:0] b;
        rst_n_i = 1'b0;
        idle();
        bus.in_opcode_i  = '0;
        bus.in_rs_addr_i = '0;
        bus.in_rt_addr_i = '0;
        bus.in_rd_addr_i = '0;
        bus.wb_addr_i    = '0;
        bus.wb_data_i    = '0;
        bus.out_ready_i  = 1'b1;
        tick();
        tick();
        rst_n_i = 1'b1;

        // Reset state
        @(negedge clk_i);
        check("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready_o},  32'd1);
        check("rst_count",     {24'd0, bus.issue_count_o}, 32'd0);
        check("rst_rs",        {24'd0, bus.rs_o}, 32'd0);
        check("rst_rt",        {24'd0, bus.rt_o}, 32'd0);
        tick();

        // Read r1/r2 straight out of reset
        set_instr(3'b101, 3'd1, 3'd2, 3'd5);
        sb.push_back('{3'b101, 8'h00, 8'h00, 3'd5});
        tick();
        idle();

        // Write r1, r2 then issue
        set_wb(3'd1, 8'h55);
        tick();
        set_wb(3'd2, 8'hAA);
        tick();
        idle();
        set_instr(3'b000, 3'd1, 3'd2, 3'd3);
        sb.push_back('{3'b000, 8'h55, 8'hAA, 3'd3});
        tick();

        // Bypass on rs, r0 on rt; then read r4 back from the file
        set_wb(3'd4, 8'h0F);
        set_instr(3'b010, 3'd4, 3'd0, 3'd6);
        sb.push_back('{3'b010, 8'h0F, 8'h00, 3'd6});
        tick();
        bus.wb_en_i = 1'b0;
        set_instr(3'b011, 3'd4, 3'd4, 3'd7);
        sb.push_back('{3'b011, 8'h0F, 8'h0F, 3'd7});
        tick();

        // r0 write ignored, including same-cycle bypass
        set_wb(3'd0, 8'hFF);
        set_instr(3'b100, 3'd0, 3'd0, 3'd1);
        sb.push_back('{3'b100, 8'h00, 8'h00, 3'd1});
        tick();
        bus.wb_en_i = 1'b0;
        set_instr(3'b111, 3'd0, 3'd1, 3'd0);
        sb.push_back('{3'b111, 8'h00, 8'h55, 3'd0});
        tick();
        idle();
        tick();

        // Backpressure: A stalls, B waits; writeback to r2 during stall
        bus.out_ready_i = 1'b0;
        set_instr(3'b001, 3'd2, 3'd1, 3'd2);
        sb.push_back('{3'b001, 8'hAA, 8'h55, 3'd2});
        tick();
        set_instr(3'b110, 3'd4, 3'd2, 3'd3);
        sb.push_back('{3'b110, 8'h0F, 8'h33, 3'd3});
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_wb(3'd2, 8'h33);
            @(negedge clk_i);
            check("stall_in_ready",  {31'd0, bus.in_ready_o},  32'd0);
            check("stall_out_valid", {31'd0, bus.out_valid_o}, 32'd1);
            check("stall_rs",        {24'd0, bus.rs_o},        32'h0000_00AA);
            check("stall_rt",        {24'd0, bus.rt_o},        32'h0000_0055);
            check("stall_opcode",    {29'd0, bus.opcode_o},    32'd1);
            check("stall_count",     {24'd0, bus.issue_count_o}, 32'd7);
            tick();
            bus.wb_en_i = 1'b0;
        end
        bus.out_ready_i = 1'b1;
        tick();
        idle();
        @(negedge clk_i);
        check("no_bubble_valid", {31'd0, bus.out_valid_o}, 32'd1);
        check("bp_count",        {24'd0, bus.issue_count_o}, 32'd8);
        tick();

        // Counter wrap: 248 more accepts bring the count from 8 to 256 == 0
        for (int i = 0; i < 248; i++) begin
            a = 3'(i);
            b = 3'(i + 3);
            set_instr(3'(i + 1), a, b, a);
            sb.push_back('{3'(i + 1), reg_img[a], reg_img[b], a});
            if (i == 247) begin
                @(negedge clk_i);
                check("count_255", {24'd0, bus.issue_count_o}, 32'd255);
            end
            tick();
        end
        idle();
        @(negedge clk_i);
        check("count_wrap", {24'd0, bus.issue_count_o}, 32'd0);
        tick();

        // Mid-stall asynchronous reset discards the pending instruction
        bus.out_ready_i = 1'b0;
        set_instr(3'b101, 3'd1, 3'd4, 3'd6);
        tick();
        idle();
        @(negedge clk_i);
        check("pre_rst_valid", {31'd0, bus.out_valid_o}, 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("async_rst_rs",    {24'd0, bus.rs_o}, 32'd0);
        check("async_rst_count", {24'd0, bus.issue_count_o}, 32'd0);
        tick();
        rst_n_i = 1'b1;
        bus.out_ready_i = 1'b1;
        tick();

        // Register file cleared by reset
        set_instr(3'b010, 3'd1, 3'd4, 3'd2);
        sb.push_back('{3'b010, 8'h00, 8'h00, 3'd2});
        tick();
        idle();

        // Drain scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end
endmodule
